// File: rtl/program_memory_loader_pkg.sv
// Shared constants for the program memory loader and the program memory's
// byte-address to word-index conversion.
package program_memory_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int BYTE_WIDTH = 8;
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/program_memory_loader_packer.sv
// Big-endian byte packer: shifts bytes in MSB-first and flags the byte that
// completes a word, presenting the complete word combinationally on that cycle.
module program_memory_loader_packer
  import program_memory_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_byte_valid,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_word_ready
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / BYTE_WIDTH;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD + 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;

  // Earlier bytes migrate toward the MSBs, so byte 0 ends up in the top lane.
  assign o_word       = DATA_WIDTH'({r_shift, i_byte});
  assign o_word_ready = i_byte_valid && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_byte_valid) begin
      r_cnt <= o_word_ready ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Stale contents are fully shifted out by the next word's bytes.
  always_ff @(posedge clk) begin
    if (i_byte_valid) begin
      r_shift <= o_word;
    end
  end

endmodule

// File: rtl/program_memory_loader.sv
// Loads a byte stream into program memory as big-endian instructions while
// holding the CPU, then reports Done (or Error for an oversized request).
module program_memory_loader
  import program_memory_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 1024,
  parameter int DATA_WIDTH   = 32,
  parameter int BASE_ADDRESS = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            Start,
  input  logic [$clog2(MEMORY_DEPTH):0]   WordCount,
  input  logic [BYTE_WIDTH-1:0]           ByteIn,
  input  logic                            ByteValid,
  output logic                            ByteReady,
  output logic                            MemWriteEnable,
  output logic [DATA_WIDTH-1:0]           MemWriteAddress,
  output logic [DATA_WIDTH-1:0]           MemWriteData,
  output logic                            CpuHold,
  output logic                            Done,
  output logic                            Error
);

  localparam int ADDR_WIDTH = $clog2(MEMORY_DEPTH);
  localparam int CW         = ADDR_WIDTH + 1;

  state_t                r_state, w_state_next;
  logic [CW-1:0]         r_count, r_word_idx;
  logic [DATA_WIDTH-1:0] r_addr, r_data;
  logic                  r_error;
  logic                  w_start_ok, w_start_zero, w_start_bad;
  logic                  w_xfer, w_word_ready, w_last_word;
  logic [DATA_WIDTH-1:0] w_word;

  assign ByteReady       = (r_state == ST_RECEIVE);
  assign MemWriteEnable  = (r_state == ST_WRITE);
  assign CpuHold         = (r_state == ST_RECEIVE) || (r_state == ST_WRITE);
  assign Done            = (r_state == ST_DONE);
  assign Error           = r_error;
  assign MemWriteAddress = r_addr;
  assign MemWriteData    = r_data;
  assign w_xfer          = ByteValid && ByteReady;
  assign w_last_word     = ((r_word_idx + CW'(1)) == r_count);

  program_memory_loader_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_start_ok),
    .i_byte_valid (w_xfer),
    .i_byte       (ByteIn),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_start_zero = 1'b0;
    w_start_bad  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          if (WordCount > CW'(MEMORY_DEPTH)) begin
            w_start_bad  = 1'b1;
            w_state_next = ST_IDLE;
          end else if (WordCount == '0) begin
            w_start_zero = 1'b1;
            w_state_next = ST_DONE;
          end else begin
            w_start_ok   = 1'b1;
            w_state_next = ST_RECEIVE;
          end
        end
      end
      ST_RECEIVE: if (w_word_ready) w_state_next = ST_WRITE;
      ST_WRITE:   w_state_next = w_last_word ? ST_DONE : ST_RECEIVE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Address and data are registered on the completing byte so the write
  // strobe sees stable values for its whole cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_word_idx <= '0;
      r_error    <= 1'b0;
      r_addr     <= DATA_WIDTH'(BASE_ADDRESS);
      r_data     <= '0;
    end else begin
      if (w_start_bad) r_error <= 1'b1;
      if (w_start_ok || w_start_zero) begin
        r_error    <= 1'b0;
        r_count    <= WordCount;
        r_word_idx <= '0;
      end
      if ((r_state == ST_RECEIVE) && w_word_ready) begin
        r_data <= w_word;
        r_addr <= DATA_WIDTH'(BASE_ADDRESS) + (DATA_WIDTH'(r_word_idx) << WORD_SHIFT);
      end
      if (r_state == ST_WRITE) r_word_idx <= r_word_idx + CW'(1);
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Scoreboard bench for program_memory_loader: expected writes are queued as
// bytes are driven and retired against every MemWriteEnable strobe.
module tb_program_memory_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [10:0] WordCount;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady, MemWriteEnable, CpuHold, Done, Error;
  logic [31:0] MemWriteAddress, MemWriteData;

  program_memory_loader dut (
    .clk             (clk),
    .reset           (reset),
    .Start           (Start),
    .WordCount       (WordCount),
    .ByteIn          (ByteIn),
    .ByteValid       (ByteValid),
    .ByteReady       (ByteReady),
    .MemWriteEnable  (MemWriteEnable),
    .MemWriteAddress (MemWriteAddress),
    .MemWriteData    (MemWriteData),
    .CpuHold         (CpuHold),
    .Done            (Done),
    .Error           (Error)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_err = 0;
  int          cyc = 0, n_writes = 0, n_rdy_viol = 0;
  int          last_wr_cyc = 0, last_gap = 0;
  logic [31:0] last_addr = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_e;
  logic [31:0] mem  [0:1023];
  logic [31:0] gold [0:1023];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Program memory model plus write monitor.
  always @(negedge clk) begin
    if (!reset && MemWriteEnable) begin
      n_writes++;
      if (sb.size() == 0) begin
        check_val("unexpected_write", MemWriteAddress, 32'hFFFF_FFFF);
      end else begin
        exp_e = sb.pop_front();
        check_val("wr_addr", MemWriteAddress, exp_e[63:32]);
        check_val("wr_data", MemWriteData, exp_e[31:0]);
      end
      mem[MemWriteAddress[11:2]] = MemWriteData;
      last_gap    = cyc - last_wr_cyc;
      last_wr_cyc = cyc;
      last_addr   = MemWriteAddress;
    end
    if (CpuHold && !MemWriteEnable && !ByteReady) n_rdy_viol++;
  end

  task automatic start_load(input int n);
    @(negedge clk);
    Start = 1'b1;
    WordCount = 11'(n);
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) begin
      @(negedge clk);
      ByteValid = 1'b0;
    end
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      ByteValid = 1'b1;
      ByteIn = b;
      if (ByteReady) break;
    end
    if (k == 64) check_val("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input logic [31:0] addr);
    sb.push_back({addr, w});
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    ByteValid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 100; k++) begin
      if (Done) break;
      @(negedge clk);
    end
    if (k == 100) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w0;
    logic [31:0] w;
    logic [31:0] bytes5 [0:1];
    reset = 1'b1; Start = 1'b0; WordCount = '0; ByteIn = '0; ByteValid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ready",  ByteReady,       0);
    check_val("rst_we",     MemWriteEnable,  0);
    check_val("rst_hold",   CpuHold,         0);
    check_val("rst_done",   Done,            0);
    check_val("rst_error",  Error,           0);
    check_val("rst_addr",   MemWriteAddress, 0);
    check_val("rst_data",   MemWriteData,    0);
    reset = 1'b0;

    // Two words, ByteValid held high.
    w0 = n_writes;
    start_load(2);
    check_val("t1_hold_busy",  CpuHold,   1);
    check_val("t1_ready_busy", ByteReady, 1);
    send_word(32'h2008_0005, 0, 32'h0);
    send_word(32'hAC09_0000, 0, 32'h4);
    idle_bus();
    wait_done();
    check_val("t1_done",   Done,          1);
    check_val("t1_hold",   CpuHold,       0);
    check_val("t1_gap",    last_gap,      5);
    check_val("t1_writes", n_writes - w0, 2);

    // Same load with 3-cycle gaps between bytes.
    w0 = n_writes;
    n_rdy_viol = 0;
    start_load(2);
    send_word(32'h2008_0005, 3, 32'h0);
    send_word(32'hAC09_0000, 3, 32'h4);
    idle_bus();
    wait_done();
    check_val("t2_done",      Done,          1);
    check_val("t2_writes",    n_writes - w0, 2);
    check_val("t2_ready_gap", n_rdy_viol,    0);

    // Oversized request, then a zero-length one.
    w0 = n_writes;
    start_load(1025);
    repeat (3) @(negedge clk);
    check_val("t3_error", Error,     1);
    check_val("t3_ready", ByteReady, 0);
    check_val("t3_done",  Done,      0);
    check_val("t3_hold",  CpuHold,   0);
    start_load(0);
    check_val("t3_zero_done",  Done,  1);
    check_val("t3_zero_error", Error, 0);
    repeat (2) @(negedge clk);
    check_val("t3_writes", n_writes - w0, 0);

    // Reset in the middle of the first word.
    w0 = n_writes;
    start_load(3);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    ByteValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("t4_hold",  CpuHold,        0);
    check_val("t4_ready", ByteReady,      0);
    check_val("t4_done",  Done,           0);
    check_val("t4_we",    MemWriteEnable, 0);
    start_load(1);
    send_word(32'hCAFE_F00D, 0, 32'h0);
    idle_bus();
    wait_done();
    check_val("t4_writes", n_writes - w0, 1);

    // Start pulse during RECEIVE must be ignored.
    w0 = n_writes;
    bytes5[0] = 32'h0102_0304;
    bytes5[1] = 32'hA5B6_C7D8;
    start_load(2);
    sb.push_back({32'h0, bytes5[0]});
    sb.push_back({32'h4, bytes5[1]});
    for (int i = 0; i < 8; i++) begin
      w = bytes5[i/4];
      if (i == 2) begin
        @(negedge clk);
        ByteValid = 1'b0;
        Start = 1'b1;
        WordCount = 11'd1;
        @(negedge clk);
        Start = 1'b0;
      end
      send_byte(w[31-8*(i%4) -: 8], 0);
    end
    idle_bus();
    wait_done();
    check_val("t5_writes", n_writes - w0, 2);
    check_val("t5_last",   last_addr,     32'h4);

    // Full memory with random bytes, then read back.
    start_load(1024);
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      gold[i] = w;
      send_word(w, 0, 32'(i * 4));
    end
    idle_bus();
    wait_done();
    check_val("t6_done",     Done,      1);
    check_val("t6_last",     last_addr, 32'hFFC);
    check_val("t6_sb_empty", sb.size(), 0);
    for (int i = 0; i < 1024; i++) check_val("t6_readback", mem[i], gold[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
